// File: rtl/cheat_code_loader.sv
// cheat_code_loader
// Assembles 16-byte cheat records arriving as 16-bit ioctl words into the
// cheat engine's 129-bit code bus and hands each one over with a
// low-high-low strobe on code[128], stalling the HPS with ioctl_wait while
// the hand-over runs. Clears the engine at the start of every cheat download.
// Optional feature: define CHEAT_LOADER_ZERO_SKIP_EN to silently drop records
// whose 128 payload bits are all zero (padding records use no engine slot).
module cheat_code_loader #(
  parameter int MAX_CODES     = 32,
  parameter int STROBE_CYCLES = 2,
  localparam int CW = $clog2(MAX_CODES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cheat_sel,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [15:0]   ioctl_dout,
  output logic          ioctl_wait,
  output logic          engine_clear,
  output logic [128:0]  code,
  output logic [CW-1:0] code_count,
  output logic          overflow
);

  localparam int TW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HIGH,
    S_LOW
  } state_t;

  state_t        state_reg;
  logic [TW-1:0] timer_reg;
  logic          sel_dl_reg;
  logic          wait_reg;
  logic          clear_reg;
  logic [128:0]  code_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;

  // Assembly buffer, one entry per file byte of the record.
  logic [7:0]    asm_reg  [16];
  logic [7:0]    asm_next [16];

  logic          sel_dl;
  logic          dl_start;
  logic          wr_accept;
  logic [2:0]    slot;
  logic          commit;
  logic          timer_last;
  logic          payload_zero;
  logic [127:0]  payload;

  // Only address bits [3:1] select a slot; the rest carry no information here.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{ioctl_addr[24:4], ioctl_addr[0]};

  assign sel_dl     = cheat_sel & ioctl_download;
  assign dl_start   = sel_dl & ~sel_dl_reg;
  assign wr_accept  = sel_dl & ioctl_wr;
  assign slot       = ioctl_addr[3:1];
  assign timer_last = (timer_reg == TW'(STROBE_CYCLES - 1));

  // A slot-7 write commits only while idle; writes during a hand-over break
  // the handshake and are merely captured. The start cycle never commits.
  assign commit = wr_accept & (slot == 3'd7) & (state_reg == S_IDLE) & ~dl_start;

  // Byte gi of the record lands in buffer entry gi. The payload is taken from
  // the post-write view so the committing slot-7 word is part of the code.
  // Field gi/4 (flags, addr, compare, replace) is little-endian in the file,
  // so byte gi%4 is placed at bit offset 8*(gi%4) of its 32-bit field.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      assign asm_next[gi] = dl_start ? 8'h00 :
                            (wr_accept && slot == 3'(gi / 2)) ?
                              ((gi % 2 == 1) ? ioctl_dout[15:8] : ioctl_dout[7:0]) :
                              asm_reg[gi];
      assign payload[(3 - gi / 4) * 32 + (gi % 4) * 8 +: 8] = asm_next[gi];
    end
  endgenerate

`ifdef CHEAT_LOADER_ZERO_SKIP_EN
  assign payload_zero = ~|payload;
`else
  assign payload_zero = 1'b0;
`endif

  // Assembly buffer: zeroed on reset and on every download start.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 16; i++) begin
      asm_reg[i] <= reset ? 8'h00 : asm_next[i];
    end
  end

  // Hand-over state machine with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      sel_dl_reg   <= 1'b0;
      wait_reg     <= 1'b0;
      clear_reg    <= 1'b0;
      code_reg     <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      sel_dl_reg <= sel_dl;
      clear_reg  <= dl_start;
      if (dl_start) begin
        // New download: wipe engine-facing state and abort any hand-over.
        state_reg    <= S_IDLE;
        timer_reg    <= '0;
        wait_reg     <= 1'b0;
        code_reg     <= '0;
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (commit && !payload_zero) begin
              if (count_reg == CW'(MAX_CODES)) begin
                overflow_reg <= 1'b1;
              end else begin
                state_reg <= S_LOAD;
                code_reg  <= {1'b0, payload};
                wait_reg  <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            state_reg     <= S_HIGH;
            code_reg[128] <= 1'b1;
            timer_reg     <= '0;
          end
          S_HIGH: begin
            if (timer_last) begin
              state_reg     <= S_LOW;
              code_reg[128] <= 1'b0;
              timer_reg     <= '0;
            end else begin
              timer_reg <= timer_reg + 1'b1;
            end
          end
          S_LOW: begin
            if (timer_last) begin
              state_reg <= S_IDLE;
              wait_reg  <= 1'b0;
              count_reg <= count_reg + 1'b1;
              timer_reg <= '0;
            end else begin
              timer_reg <= timer_reg + 1'b1;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign ioctl_wait   = wait_reg;
  assign engine_clear = clear_reg;
  assign code         = code_reg;
  assign code_count   = count_reg;
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_cheat_code_loader.sv
// tb_cheat_code_loader
// Randomised ioctl traffic against a timeline model of the loader: every
// accepted commit at cycle T predicts the wait window, the strobe window and
// the count step as plain cycle arithmetic. A per-cycle compare checks all
// outputs; directed scenarios add literal expectations.
`timescale 1ns/1ps
module tb_cheat_code_loader;

  localparam int MAXC = 32;
  localparam int S    = 2;
  localparam int CW   = $clog2(MAXC + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          cheat_sel;
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [15:0]   ioctl_dout;
  logic          ioctl_wait;
  logic          engine_clear;
  logic [128:0]  code;
  logic [CW-1:0] code_count;
  logic          overflow;

  cheat_code_loader #(
    .MAX_CODES    (MAXC),
    .STROBE_CYCLES(S)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cheat_sel     (cheat_sel),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .engine_clear  (engine_clear),
    .code          (code),
    .code_count    (code_count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // DUT event counters (monitor-owned)
  int rises = 0, clears = 0, wait_hi = 0, strobe_hi = 0;
  bit prev_strobe = 1'b0;

  // Model state
  bit           mvalid = 1'b0;
  bit           mprev_sel;
  logic [7:0]   mb [16];
  logic [127:0] m_payload;
  int           m_count;
  bit           m_ovf;
  bit           m_busy;
  int           m_t;
  int           m_clear_cyc;

  int gap_max = 2;

  task automatic cmp(input string name, input logic [128:0] act, input logic [128:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Record value from the model bytes: each field is little-endian.
  function automatic logic [127:0] record_value();
    logic [31:0] f [4];
    for (int k = 0; k < 4; k++)
      f[k] = 32'(mb[4*k]) + (32'(mb[4*k+1]) << 8) + (32'(mb[4*k+2]) << 16) + (32'(mb[4*k+3]) << 24);
    return {f[0], f[1], f[2], f[3]};
  endfunction

  task automatic monitor();
    forever begin
      bit sel, st, skip, exp_strobe;
      int slot;
      logic [127:0] p;
      @(negedge clk);
      if (mvalid) begin
        if (m_busy && cyc == m_t + 2 + 2*S) begin
          m_count++;
          m_busy = 1'b0;
        end
        exp_strobe = m_busy && cyc >= m_t + 2 && cyc <= m_t + 1 + S;
        cmp("payload", {1'b0, code[127:0]}, {1'b0, m_payload});
        cmp("strobe", 129'(code[128]), 129'(exp_strobe));
        cmp("ioctl_wait", 129'(ioctl_wait), 129'(m_busy));
        cmp("engine_clear", 129'(engine_clear), 129'(cyc == m_clear_cyc));
        cmp("code_count", 129'(code_count), 129'(m_count));
        cmp("overflow", 129'(overflow), 129'(m_ovf));
        if (code[128] && !prev_strobe) rises++;
        if (code[128]) strobe_hi++;
        if (ioctl_wait) wait_hi++;
        if (engine_clear) clears++;
      end
      prev_strobe = code[128];
      // absorb this cycle's inputs into the model
      if (reset) begin
        mvalid      = 1'b1;
        mprev_sel   = 1'b0;
        m_payload   = '0;
        m_count     = 0;
        m_ovf       = 1'b0;
        m_busy      = 1'b0;
        m_t         = -100;
        m_clear_cyc = -1;
        for (int i = 0; i < 16; i++) mb[i] = 8'h00;
      end else if (mvalid) begin
        sel = cheat_sel && ioctl_download;
        st  = sel && !mprev_sel;
        if (st) begin
          m_clear_cyc = cyc + 1;
          m_count     = 0;
          m_ovf       = 1'b0;
          m_payload   = '0;
          m_busy      = 1'b0;
          for (int i = 0; i < 16; i++) mb[i] = 8'h00;
        end
        if (sel && ioctl_wr) begin
          slot = int'(ioctl_addr[3:1]);
          mb[2*slot]   = ioctl_dout[7:0];
          mb[2*slot+1] = ioctl_dout[15:8];
          if (slot == 7 && !st && !m_busy) begin
            p    = record_value();
            skip = 1'b0;
`ifdef CHEAT_LOADER_ZERO_SKIP_EN
            skip = (p == '0);
`endif
            if (!skip) begin
              if (m_count == MAXC) m_ovf = 1'b1;
              else begin
                m_busy    = 1'b1;
                m_t       = cyc;
                m_payload = p;
              end
            end
          end
        end
        mprev_sel = sel;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [15:0] d, input bit force_wr);
    int g = 0;
    while (ioctl_wait && !force_wr && g < 200) begin tick(); g++; end
    if (g >= 200) begin
      checks++; errors++;
      $display("FAIL wait_timeout cyc=%0d actual=wait_high required=wait_low", cyc);
    end
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
    repeat ($urandom_range(0, gap_max)) tick();
  endtask

  // File image of a record: byte i of the record sits at rec[8i +: 8].
  function automatic logic [127:0] mk_rec(input logic [31:0] fl, ad, cp, rp);
    return {rp, cp, ad, fl};
  endfunction

  // Slots lo..hi-1 in rotated order, then slot hi last.
  task automatic send_slots(input logic [127:0] rec, input int idx, input int lo,
                            input int hi, input bit force_wr);
    int n, rot, s;
    n   = hi - lo;
    rot = $urandom_range(0, 15);
    for (int j = 0; j < n; j++) begin
      s = lo + (j + rot) % n;
      write_word(idx*16 + 2*s, rec[16*s +: 16], force_wr);
    end
    write_word(idx*16 + 2*hi, rec[16*hi +: 16], force_wr);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (ioctl_wait && g < 100) begin tick(); g++; end
    if (ioctl_wait) begin
      checks++; errors++;
      $display("FAIL idle_timeout cyc=%0d actual=wait_high required=wait_low", cyc);
    end
    tick(); tick();
  endtask

  task automatic start_dl();
    cheat_sel = 1'b1; ioctl_download = 1'b1;
    tick(); tick();
  endtask

  task automatic end_dl();
    cheat_sel = 1'b0; ioctl_download = 1'b0;
    tick(); tick();
  endtask

  function automatic logic [127:0] rnd_rec();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    r[0] = 1'b1;
    return r;
  endfunction

  task automatic stimulus();
    int r0, w0, s0, c0, g;
    logic [127:0] rec;
    repeat (3) tick();
    cmp("rst_code", code, 129'd0);
    cmp("rst_wait", 129'(ioctl_wait), 129'd0);
    cmp("rst_clear", 129'(engine_clear), 129'd0);
    cmp("rst_count", 129'(code_count), 129'd0);
    cmp("rst_overflow", 129'(overflow), 129'd0);
    reset = 1'b0;
    tick();

    // first record, exact values
    c0 = clears;
    start_dl();
    w0 = wait_hi; s0 = strobe_hi;
    send_slots(mk_rec(32'h00000021, 32'h000A1234, 32'h0, 32'h000000FF), 0, 0, 7, 1'b0);
    wait_idle();
    cmp("rec1_code", {1'b0, code[127:0]}, {1'b0, 128'h00000021_000A1234_00000000_000000FF});
    cmp("rec1_strobe_cycles", 129'(strobe_hi - s0), 129'd2);
    cmp("rec1_wait_cycles", 129'(wait_hi - w0), 129'd5);
    cmp("rec1_count", 129'(code_count), 129'd1);
    cmp("rec1_clears", 129'(clears - c0), 129'd1);

    // two more, then a second download start
    for (int i = 1; i < 3; i++) send_slots(rnd_rec(), i, 0, 7, 1'b0);
    wait_idle();
    cmp("three_count", 129'(code_count), 129'd3);
    end_dl();
    c0 = clears;
    start_dl();
    cmp("restart_clears", 129'(clears - c0), 129'd1);
    cmp("restart_count", 129'(code_count), 129'd0);
    cmp("restart_code", code, 129'd0);
    cmp("restart_overflow", 129'(overflow), 129'd0);

    // 33 records into a 32-entry engine
    r0 = rises;
    for (int i = 0; i < 33; i++) send_slots(rnd_rec(), i, 0, 7, 1'b0);
    wait_idle();
    cmp("full_rises", 129'(rises - r0), 129'd32);
    cmp("full_count", 129'(code_count), 129'd32);
    cmp("full_overflow", 129'(overflow), 129'd1);

    // all-zero record
    end_dl();
    start_dl();
    r0 = rises;
    send_slots('0, 0, 0, 7, 1'b0);
    wait_idle();
`ifdef CHEAT_LOADER_ZERO_SKIP_EN
    cmp("zero_rises", 129'(rises - r0), 129'd0);
    cmp("zero_count", 129'(code_count), 129'd0);
`else
    cmp("zero_rises", 129'(rises - r0), 129'd1);
    cmp("zero_count", 129'(code_count), 129'd1);
`endif

    // partial record then a fresh download without stale bytes
    end_dl();
    start_dl();
    r0 = rises;
    send_slots({128{1'b1}}, 0, 0, 4, 1'b0);
    end_dl();
    cmp("partial_rises", 129'(rises - r0), 129'd0);
    cmp("partial_count", 129'(code_count), 129'd0);
    start_dl();
    send_slots(mk_rec(32'hDEADBEEF, 32'h11223344, 32'h55667788, 32'h99AABBCC), 0, 2, 7, 1'b0);
    wait_idle();
    cmp("nostale_code", {1'b0, code[127:0]}, {1'b0, 128'h00000000_11223344_55667788_99AABBCC});
    cmp("nostale_count", 129'(code_count), 129'd1);

    // reset while the strobe is high
    gap_max = 0;
    send_slots(rnd_rec(), 1, 0, 7, 1'b0);
    g = 0;
    while (!code[128] && g < 20) begin tick(); g++; end
    cmp("high_reached", 129'(code[128]), 129'd1);
    reset = 1'b1;
    tick();
    cmp("rst_high_strobe", 129'(code[128]), 129'd0);
    cmp("rst_high_wait", 129'(ioctl_wait), 129'd0);
    reset = 1'b0;
    tick(); tick();
    gap_max = 2;
    r0 = rises;
    send_slots(rnd_rec(), 0, 0, 7, 1'b0);
    wait_idle();
    cmp("post_rst_rises", 129'(rises - r0), 129'd1);
    cmp("post_rst_count", 129'(code_count), 129'd1);

    // randomised traffic
    for (int i = 0; i < 70; i++) begin
      int act;
      act = $urandom_range(0, 11);
      if (act == 0) begin
        end_dl();
        start_dl();
      end else if (act == 1) begin
        send_slots(rnd_rec(), i % 40, 0, $urandom_range(0, 6), 1'b0);
      end else begin
        rec = ($urandom_range(0, 7) == 0) ? '0 : rnd_rec();
        send_slots(rec, i % 40, 0, 7, ($urandom_range(0, 9) == 0));
      end
    end
    wait_idle();
    end_dl();
  endtask

  initial begin
    reset = 1'b1; cheat_sel = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0;
    fork
      monitor();
      stimulus();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
